// File: rtl/jtag_pkg.sv
// Shared types and TMS/TRSTn schedule constants for the JTAG scan master.
// TMS patterns are stored LSB first: bit k is the TMS value of tick k.
package jtag_pkg;

   typedef enum logic [1:0] {
      OP_RESET   = 2'd0,
      OP_IDLE    = 2'd1,
      OP_SCAN_IR = 2'd2,
      OP_SCAN_DR = 2'd3
   } jtag_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_RSP  = 2'd2
   } jtag_state_e;

   localparam logic [2:0] DR_PRE           = 3'b001;
   localparam logic [3:0] IR_PRE           = 4'b0011;
   localparam logic [1:0] POST             = 2'b01;
   localparam logic [5:0] RESET_TMS        = 6'b011111;
   localparam int         RESET_TICKS      = 6;
   localparam int         RESET_TRST_TICKS = 2;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: half-period counter reloaded with the latched divider.
// Strobes fire in the cycle before TCK toggles, so the top can act on the same edge.
module jtag_tck_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             rise_stb_o,
   output logic             fall_stb_o,
   output logic             tck_o
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tck_q, tck_d;
   logic             wrap;

   assign wrap       = en_i && (cnt_q == '0);
   assign rise_stb_o = wrap && !tck_q;
   assign fall_stb_o = wrap && tck_q;
   assign tck_o      = tck_q;

   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      tck_d = tck_q;
      if (load_i) begin
         div_d = div_i;
         cnt_d = div_i;
         tck_d = 1'b0;
      end else if (wrap) begin
         cnt_d = div_q;
         tck_d = !tck_q;
      end else if (en_i) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

   always_ff @(posedge clk_i) begin
      div_q <= div_d;
   end

endmodule

// File: rtl/jtag_scan_master.sv
// Command-level JTAG master: turns RESET/IDLE/SCAN_IR/SCAN_DR commands into
// a registered TCK/TMS/TDI/TRSTn tick schedule and returns the captured TDO.
module jtag_scan_master
   import jtag_pkg::*;
#(
   parameter int MAX_LEN = 64,
   parameter int DIV_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [DIV_W-1:0]   cfg_div,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               rsp_err,
   output logic               busy,
   output logic               tap_sync,
   output logic               jtag_TCK,
   output logic               jtag_TMS,
   output logic               jtag_TDI,
   output logic               jtag_TRSTn,
   input  logic               jtag_TDO
);

   localparam int               NW        = LEN_W + 3;
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   function automatic logic [NW-1:0] pre_len(input jtag_op_e op);
      case (op)
         OP_SCAN_IR: pre_len = NW'(4);
         OP_SCAN_DR: pre_len = NW'(3);
         default:    pre_len = '0;
      endcase
   endfunction

   function automatic logic [NW-1:0] num_ticks(input jtag_op_e op, input logic [LEN_W-1:0] len);
      case (op)
         OP_RESET: num_ticks = NW'(RESET_TICKS);
         OP_IDLE:  num_ticks = NW'(len);
         default:  num_ticks = pre_len(op) + NW'(len) + NW'(2);
      endcase
   endfunction

   function automatic logic is_shift(input jtag_op_e op, input logic [LEN_W-1:0] len,
                                     input logic [NW-1:0] k);
      is_shift = (op == OP_SCAN_IR || op == OP_SCAN_DR) &&
                 (k >= pre_len(op)) && (k < pre_len(op) + NW'(len));
   endfunction

   function automatic logic tick_tms(input jtag_op_e op, input logic [LEN_W-1:0] len,
                                     input logic [NW-1:0] k);
      logic [NW-1:0] post_k;
      post_k   = pre_len(op) + NW'(len);
      tick_tms = 1'b0;
      case (op)
         OP_RESET: if (k < NW'(RESET_TICKS)) tick_tms = RESET_TMS[k[2:0]];
         OP_IDLE:  tick_tms = 1'b0;
         default: begin
            if (k < pre_len(op))
               tick_tms = (op == OP_SCAN_IR) ? IR_PRE[k[1:0]] : DR_PRE[k[1:0]];
            else if (k < post_k)
               tick_tms = (k == post_k - 1'b1);
            else
               tick_tms = (k == post_k) ? POST[0] : POST[1];
         end
      endcase
   endfunction

   jtag_state_e        state_q, state_d;
   jtag_op_e           op_q, op_d, cmd_op_e;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [NW-1:0]      n_q, n_d, k_q, k_d, k_nxt;
   logic [MAX_LEN-1:0] sr_q, sr_d, cap_q, cap_d;
   logic               err_q, err_d, sync_q, sync_d;
   logic               tms_q, tms_d, tdi_q, tdi_d, trstn_q, trstn_d;
   logic               accept, rise_stb, fall_stb, tck;
   logic               scan_op, bad_len;

   assign cmd_op_e  = jtag_op_e'(cmd_op);
   assign cmd_ready = (state_q == S_IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;
   assign k_nxt     = k_q + 1'b1;
   assign scan_op   = (cmd_op_e == OP_SCAN_IR) || (cmd_op_e == OP_SCAN_DR);
   assign bad_len   = (cmd_len == '0) || (cmd_len > MAX_LEN_L);

   jtag_tck_gen #(.DIV_W(DIV_W)) u_tck_gen (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (accept),
      .en_i       (state_q == S_RUN),
      .div_i      (cfg_div),
      .rise_stb_o (rise_stb),
      .fall_stb_o (fall_stb),
      .tck_o      (tck)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      len_d   = len_q;
      n_d     = n_q;
      k_d     = k_q;
      sr_d    = sr_q;
      cap_d   = cap_q;
      err_d   = err_q;
      sync_d  = sync_q;
      tms_d   = tms_q;
      tdi_d   = tdi_q;
      trstn_d = trstn_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d  = cmd_op_e;
               len_d = cmd_len;
               k_d   = '0;
               sr_d  = cmd_data;
               cap_d = '0;
               err_d = scan_op && bad_len;
               if ((scan_op && bad_len) || (cmd_op_e == OP_IDLE && cmd_len == '0)) begin
                  state_d = S_RSP;
               end else begin
                  // Tick 0 is never a shift tick, so TDI starts low.
                  state_d = S_RUN;
                  n_d     = num_ticks(cmd_op_e, cmd_len);
                  tms_d   = tick_tms(cmd_op_e, cmd_len, '0);
                  tdi_d   = 1'b0;
                  trstn_d = (cmd_op_e != OP_RESET);
               end
            end
         end
         S_RUN: begin
            // Next TDI bit is pre-shifted to sr_q[0] while TCK is high.
            if (rise_stb && is_shift(op_q, len_q, k_q))
               sr_d = sr_q >> 1;
            if (fall_stb) begin
               if (is_shift(op_q, len_q, k_q))
                  cap_d = cap_q | (MAX_LEN'(jtag_TDO) << (k_q - pre_len(op_q)));
               if (k_q == n_q - 1'b1) begin
                  state_d = S_RSP;
                  tms_d   = 1'b0;
                  tdi_d   = 1'b0;
                  trstn_d = 1'b1;
                  if (op_q == OP_RESET) sync_d = 1'b1;
               end else begin
                  k_d     = k_nxt;
                  tms_d   = tick_tms(op_q, len_q, k_nxt);
                  tdi_d   = is_shift(op_q, len_q, k_nxt) ? sr_q[0] : 1'b0;
                  trstn_d = !(op_q == OP_RESET && k_nxt < NW'(RESET_TRST_TICKS));
               end
            end
         end
         S_RSP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cap_q   <= '0;
         err_q   <= 1'b0;
         sync_q  <= 1'b0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         trstn_q <= 1'b1;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cap_q   <= cap_d;
         err_q   <= err_d;
         sync_q  <= sync_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         trstn_q <= trstn_d;
      end
   end

   always_ff @(posedge clock) begin
      op_q  <= op_d;
      len_q <= len_d;
      n_q   <= n_d;
      sr_q  <= sr_d;
   end

   assign rsp_valid  = (state_q == S_RSP);
   assign busy       = (state_q == S_RUN);
   assign rsp_data   = cap_q;
   assign rsp_err    = err_q;
   assign tap_sync   = sync_q;
   assign jtag_TCK   = tck;
   assign jtag_TMS   = tms_q;
   assign jtag_TDI   = tdi_q;
   assign jtag_TRSTn = trstn_q;

endmodule
